// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory-access stage.
// Width codes and FSM states are also used by ID and EX.
package mem_access_pkg;

    localparam int ADDR_LEN = 32;
    localparam int REG_LEN  = 32;

    localparam logic [2:0] WIDTH_NONE = 3'd0;
    localparam logic [2:0] WIDTH_B    = 3'd1;
    localparam logic [2:0] WIDTH_H    = 3'd2;
    localparam logic [2:0] WIDTH_W    = 3'd4;

    localparam int WIDTH_UNSIGNED_BIT = 3;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT_LAST,
        DONE
    } mem_state_e;

    function automatic logic misaligned(
        input logic [2:0] n,
        input logic [1:0] a
    );
        return (n == WIDTH_H && a[0]) ||
               (n == WIDTH_W && a != 2'b00);
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Byte-wide memory-controller port.
// One byte moves per mem_req & mem_gnt handshake.
interface mem_access_if #(
    parameter int AddrLen = 32
);
    logic               mem_req;
    logic               mem_we;
    logic [AddrLen-1:0] mem_a;
    logic [7:0]         mem_dout;
    logic               mem_gnt;
    logic [7:0]         mem_din;

    modport master (
        output mem_req,
        output mem_we,
        output mem_a,
        output mem_dout,
        input  mem_gnt,
        input  mem_din
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_a,
        input  mem_dout,
        output mem_gnt,
        output mem_din
    );
endinterface

// File: rtl/mem_access_load_extend.sv
// Sign/zero extension of an assembled load buffer.
// Shared with the data cache refill path.
module load_extend
    import mem_access_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [2:0]  nbytes_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic sb;
    logic sh;

    assign sb = ~unsigned_i & data_i[7];
    assign sh = ~unsigned_i & data_i[15];

    always_comb begin
        data_o = data_i;
        unique case (1'b1)
            nbytes_i == WIDTH_B:
                data_o = {{24{sb}}, data_i[7:0]};
            nbytes_i == WIDTH_H:
                data_o = {{16{sh}}, data_i[15:0]};
            default:
                data_o = data_i;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: byte-serial loads/stores, stalls the pipe.
// Define MEM_ALIGN_CHECK_EN to reject misaligned H/W accesses.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int AddrLen = 32,
    parameter int RegLen  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [RegLen-1:0]  rd_data_i,
    input  logic [4:0]         rd_addr_i,
    input  logic               rd_enable_i,
    input  logic [AddrLen-1:0] mem_addr_i,
    input  logic [3:0]         width_i,
    mem_access_if.master       mem,
    output logic [RegLen-1:0]  rd_data_o,
    output logic [4:0]         rd_addr_o,
    output logic               rd_enable_o,
    output logic               stall_req,
    output logic               misalign_o
);

    mem_state_e state_q, state_d;

    logic [AddrLen-1:0] base_q;
    logic [RegLen-1:0]  sdata_q;
    logic [RegLen-1:0]  buf_q;
    logic [2:0]         cnt_q;
    logic [2:0]         k_q;
    logic               uns_q;
    logic               st_q;
    logic               pend_q;

    logic               wants;
    logic               is_st;
    logic               mis;
    logic               start;
    logic               acc;
    logic               last;
    logic [2:0]         km1;
    logic [1:0]         cidx;
    logic [AddrLen-1:0] addr_sel;
    logic [RegLen-1:0]  ext;

    assign wants    = width_i[2:0] != WIDTH_NONE;
    assign is_st    = ~rd_enable_i;
    assign addr_sel = is_st ? mem_addr_i : rd_data_i;
    assign acc      = mem.mem_req & mem.mem_gnt;
    assign last     = k_q == cnt_q - 3'd1;
    assign km1      = k_q - 3'd1;
    assign cidx     = km1[1:0];

`ifdef MEM_ALIGN_CHECK_EN
    assign mis = misaligned(width_i[2:0], addr_sel[1:0]);
`else
    assign mis = 1'b0;
`endif

    load_extend u_ext (
        .data_i     (buf_q),
        .nbytes_i   (cnt_q),
        .unsigned_i (uns_q),
        .data_o     (ext)
    );

    always_comb begin
        state_d      = state_q;
        start        = 1'b0;
        mem.mem_req  = 1'b0;
        mem.mem_we   = 1'b0;
        mem.mem_a    = '0;
        mem.mem_dout = '0;
        rd_data_o    = rd_data_i;
        rd_addr_o    = rd_addr_i;
        rd_enable_o  = rd_enable_i;
        stall_req    = 1'b0;
        misalign_o   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (wants && mis) begin
                    rd_enable_o = 1'b0;
                    misalign_o  = 1'b1;
                end else if (wants) begin
                    rd_enable_o = 1'b0;
                    stall_req   = 1'b1;
                    start       = 1'b1;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                rd_enable_o  = 1'b0;
                stall_req    = 1'b1;
                mem.mem_req  = 1'b1;
                mem.mem_we   = st_q;
                mem.mem_a    = base_q + {{(AddrLen-3){1'b0}}, k_q};
                mem.mem_dout = sdata_q[8*k_q[1:0] +: 8];
                if (acc && last)
                    state_d = st_q ? DONE : WAIT_LAST;
            end
            WAIT_LAST: begin
                rd_enable_o = 1'b0;
                stall_req   = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                rd_data_o   = st_q ? rd_data_i : ext;
                rd_enable_o = st_q ? 1'b0 : rd_enable_i;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Reset aborts the access at once: everything goes quiet.
        if (!rst) begin
            mem.mem_req  = 1'b0;
            mem.mem_we   = 1'b0;
            mem.mem_a    = '0;
            mem.mem_dout = '0;
            rd_data_o    = '0;
            rd_addr_o    = '0;
            rd_enable_o  = 1'b0;
            stall_req    = 1'b0;
            misalign_o   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            sdata_q <= '0;
            buf_q   <= '0;
            cnt_q   <= '0;
            k_q     <= '0;
            uns_q   <= 1'b0;
            st_q    <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) begin
                base_q  <= addr_sel;
                sdata_q <= rd_data_i;
                cnt_q   <= width_i[2:0];
                uns_q   <= width_i[WIDTH_UNSIGNED_BIT];
                st_q    <= is_st;
                k_q     <= '0;
                buf_q   <= '0;
            end
            if (acc)
                k_q <= k_q + 3'd1;
            // Read data lags acceptance by one cycle.
            pend_q <= acc & ~mem.mem_we;
            if (pend_q)
                buf_q[8*cidx +: 8] <= mem.mem_din;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed testbench for mem_access.
// Byte-wide memory model with programmable grant stalls.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] rd_data_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        rd_enable_i = 1'b0;
    logic [31:0] mem_addr_i = '0;
    logic [3:0]  width_i = '0;
    logic [31:0] rd_data_o;
    logic [4:0]  rd_addr_o;
    logic        rd_enable_o;
    logic        stall_req;
    logic        misalign_o;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mem_arr [0:1023];
    logic [31:0] req_log [$];
    logic [39:0] wr_log [$];
    logic [31:0] held_log [$];
    logic        hold_en = 1'b0;
    int          low_left = 0;

    always #5 clk = ~clk;

    mem_access_if bus ();

    mem_access dut (
        .clk         (clk),
        .rst         (rst),
        .rd_data_i   (rd_data_i),
        .rd_addr_i   (rd_addr_i),
        .rd_enable_i (rd_enable_i),
        .mem_addr_i  (mem_addr_i),
        .width_i     (width_i),
        .mem         (bus),
        .rd_data_o   (rd_data_o),
        .rd_addr_o   (rd_addr_o),
        .rd_enable_o (rd_enable_o),
        .stall_req   (stall_req),
        .misalign_o  (misalign_o)
    );

    // Memory model: write on accept, read data one cycle later.
    initial begin
        for (int i = 0; i < 1024; i++) mem_arr[i] = 8'h00;
        mem_arr[10'h100] = 8'h78;
        mem_arr[10'h101] = 8'h56;
        mem_arr[10'h102] = 8'h34;
        mem_arr[10'h103] = 8'h12;
        mem_arr[10'h104] = 8'h9A;
        mem_arr[10'h105] = 8'hBC;
        mem_arr[10'h200] = 8'h80;
        mem_arr[10'h210] = 8'h7F;
        mem_arr[10'h211] = 8'hFF;
        bus.mem_din = 8'h00;
        forever begin
            @(posedge clk);
            if (bus.mem_req && bus.mem_gnt) begin
                req_log.push_back(bus.mem_a);
                if (bus.mem_we) begin
                    mem_arr[bus.mem_a[9:0]] = bus.mem_dout;
                    wr_log.push_back({bus.mem_a, bus.mem_dout});
                end else begin
                    bus.mem_din <= mem_arr[bus.mem_a[9:0]];
                end
            end else if (bus.mem_req) begin
                held_log.push_back(bus.mem_a);
            end
        end
    end

    // Grant: optionally withheld on the second request.
    always @(negedge clk) begin
        if (hold_en && req_log.size() == 1 && low_left > 0) begin
            bus.mem_gnt = 1'b0;
            low_left = low_left - 1;
        end else begin
            bus.mem_gnt = 1'b1;
        end
    end

    task automatic do_access(
        input  logic [3:0]  w,
        input  logic [31:0] rdd,
        input  logic        ren,
        input  logic [31:0] maddr,
        output int          ncyc,
        output logic [31:0] res,
        output logic        ren_o,
        output logic        ren_seen,
        output logic        req_bad,
        output logic        tmo
    );
        @(negedge clk);
        req_log.delete();
        wr_log.delete();
        held_log.delete();
        width_i     = w;
        rd_data_i   = rdd;
        rd_enable_i = ren;
        mem_addr_i  = maddr;
        rd_addr_i   = 5'd7;
        ncyc = 0;
        res = '0;
        ren_o = 1'b0;
        ren_seen = 1'b0;
        req_bad = 1'b0;
        tmo = 1'b1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!stall_req) begin
                res = rd_data_o;
                ren_o = rd_enable_o;
                req_bad = bus.mem_req;
                tmo = 1'b0;
                break;
            end
            ncyc++;
            if (rd_enable_o) ren_seen = 1'b1;
            @(negedge clk);
        end
        @(negedge clk);
        width_i = '0;
        rd_enable_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rd_data_i = 32'h55;
        rd_enable_i = 1'b1;
        rd_addr_i = 5'd3;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (rd_data_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got=%h exp=0", rd_data_o);
        end
        checks++;
        if ({stall_req, rd_enable_o, rd_addr_o} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctl got=%b exp=0",
                     {stall_req, rd_enable_o, rd_addr_o});
        end
        checks++;
        if (bus.mem_req !== 1'b0 || dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL reset_state req=%b st=%0d exp 0/IDLE",
                     bus.mem_req, dut.state_q);
        end
        @(negedge clk);
        rd_data_i = '0;
        rd_enable_i = 1'b0;
        rd_addr_i = '0;
        rst = 1'b1;
    endtask

    task automatic test_passthrough();
        @(negedge clk);
        rd_data_i = 32'h1234;
        rd_addr_i = 5'd5;
        rd_enable_i = 1'b1;
        width_i = 4'd0;
        #1;
        checks++;
        if (rd_data_o !== 32'h1234 || rd_addr_o !== 5'd5) begin
            errors++;
            $display("FAIL pass_data got=%h/%0d exp=1234/5",
                     rd_data_o, rd_addr_o);
        end
        checks++;
        if ({rd_enable_o, stall_req, bus.mem_req, misalign_o}
            !== 4'b1000) begin
            errors++;
            $display("FAIL pass_ctl got=%b exp=1000",
                     {rd_enable_o, stall_req, bus.mem_req, misalign_o});
        end
        rd_enable_i = 1'b0;
    endtask

    task automatic test_load_word();
        int n;
        logic [31:0] r;
        logic e, es, rb, t;
        do_access(4'd4, 32'h100, 1'b1, 32'hDEAD0000,
                  n, r, e, es, rb, t);
        checks++;
        if (t !== 1'b0 || n != 6) begin
            errors++;
            $display("FAIL lw_stall got=%0d tmo=%b exp=6", n, t);
        end
        checks++;
        if (r !== 32'h12345678 || e !== 1'b1) begin
            errors++;
            $display("FAIL lw_data got=%h en=%b exp=12345678/1", r, e);
        end
        checks++;
        if (es !== 1'b0 || rb !== 1'b0) begin
            errors++;
            $display("FAIL lw_ctl en_stall=%b req_done=%b exp=0/0", es, rb);
        end
        checks++;
        if (req_log.size() != 4 || req_log[0] !== 32'h100 ||
            req_log[3] !== 32'h103) begin
            errors++;
            $display("FAIL lw_addr got n=%0d first=%h exp 4/100",
                     req_log.size(), req_log.size() ? req_log[0] : 0);
        end
    endtask

    task automatic test_load_narrow();
        int n;
        logic [31:0] r;
        logic e, es, rb, t;
        do_access(4'b0001, 32'h200, 1'b1, 32'h0, n, r, e, es, rb, t);
        checks++;
        if (r !== 32'hFFFFFF80 || n != 3 || t) begin
            errors++;
            $display("FAIL lb got=%h cyc=%0d exp=ffffff80/3", r, n);
        end
        do_access(4'b1001, 32'h200, 1'b1, 32'h0, n, r, e, es, rb, t);
        checks++;
        if (r !== 32'h00000080 || t) begin
            errors++;
            $display("FAIL lbu got=%h exp=00000080", r);
        end
        do_access(4'b0010, 32'h210, 1'b1, 32'h0, n, r, e, es, rb, t);
        checks++;
        if (r !== 32'hFFFFFF7F || n != 4 || t) begin
            errors++;
            $display("FAIL lh got=%h cyc=%0d exp=ffffff7f/4", r, n);
        end
        do_access(4'b1010, 32'h210, 1'b1, 32'h0, n, r, e, es, rb, t);
        checks++;
        if (r !== 32'h0000FF7F || t) begin
            errors++;
            $display("FAIL lhu got=%h exp=0000ff7f", r);
        end
    endtask

    task automatic test_store_stall();
        int n;
        logic [31:0] r;
        logic e, es, rb, t;
        req_log.delete();
        low_left = 3;
        hold_en = 1'b1;
        do_access(4'd4, 32'hDEADBEEF, 1'b0, 32'h300,
                  n, r, e, es, rb, t);
        hold_en = 1'b0;
        checks++;
        if (n != 8 || t) begin
            errors++;
            $display("FAIL sw_stall got=%0d tmo=%b exp=8", n, t);
        end
        checks++;
        if (e !== 1'b0 || es !== 1'b0 || r !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sw_out en=%b en_stall=%b data=%h exp 0/0/deadbeef",
                     e, es, r);
        end
        checks++;
        if (wr_log.size() != 4 || wr_log[0] !== 40'h300_EF ||
            wr_log[1] !== 40'h301_BE || wr_log[2] !== 40'h302_AD ||
            wr_log[3] !== 40'h303_DE) begin
            errors++;
            $display("FAIL sw_bytes got n=%0d exp 4 bytes EF BE AD DE",
                     wr_log.size());
        end
        checks++;
        if (held_log.size() != 3 || held_log[0] !== 32'h301 ||
            held_log[2] !== 32'h301) begin
            errors++;
            $display("FAIL sw_hold got n=%0d exp 3 at 301",
                     held_log.size());
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        wr_log.delete();
        width_i = 4'd4;
        rd_data_i = 32'hCAFEF00D;
        rd_enable_i = 1'b0;
        mem_addr_i = 32'h340;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_a !== 32'h341) begin
            errors++;
            $display("FAIL rm_pre req=%b a=%h exp 1/341",
                     bus.mem_req, bus.mem_a);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.mem_req, bus.mem_we, stall_req, rd_enable_o} !== 4'b0 ||
            bus.mem_a !== 32'h0 || rd_data_o !== 32'h0 ||
            rd_addr_o !== 5'd0) begin
            errors++;
            $display("FAIL rm_out req=%b a=%h data=%h exp all 0",
                     bus.mem_req, bus.mem_a, rd_data_o);
        end
        checks++;
        if (dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL rm_state got=%0d exp=IDLE", dut.state_q);
        end
        checks++;
        if (wr_log.size() != 1 || mem_arr[10'h340] !== 8'h0D ||
            mem_arr[10'h341] !== 8'h00) begin
            errors++;
            $display("FAIL rm_mem n=%0d m340=%h m341=%h exp 1/0d/00",
                     wr_log.size(), mem_arr[10'h340], mem_arr[10'h341]);
        end
        width_i = '0;
        rd_data_i = '0;
        mem_addr_i = '0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_misalign();
`ifdef MEM_ALIGN_CHECK_EN
        @(negedge clk);
        req_log.delete();
        width_i = 4'd4;
        rd_data_i = 32'h102;
        rd_enable_i = 1'b1;
        #1;
        checks++;
        if ({misalign_o, stall_req, bus.mem_req, rd_enable_o}
            !== 4'b1000) begin
            errors++;
            $display("FAIL mis_flag got=%b exp=1000",
                     {misalign_o, stall_req, bus.mem_req, rd_enable_o});
        end
        @(negedge clk);
        checks++;
        if (req_log.size() != 0 || dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL mis_noreq n=%0d st=%0d exp 0/IDLE",
                     req_log.size(), dut.state_q);
        end
        width_i = '0;
        rd_enable_i = 1'b0;
`else
        int n;
        logic [31:0] r;
        logic e, es, rb, t;
        do_access(4'd4, 32'h102, 1'b1, 32'h0, n, r, e, es, rb, t);
        checks++;
        if (r !== 32'hBC9A1234 || n != 6 || t) begin
            errors++;
            $display("FAIL mis_lw got=%h cyc=%0d exp=bc9a1234/6", r, n);
        end
        checks++;
        if (req_log.size() != 4 || req_log[0] !== 32'h102 ||
            req_log[3] !== 32'h105) begin
            errors++;
            $display("FAIL mis_addr n=%0d exp 4 from 102 to 105",
                     req_log.size());
        end
`endif
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load_word();
        test_load_narrow();
        test_store_stall();
        test_reset_mid();
        test_misalign();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage directly downstream of the execute stage, fed through the EX/MEM pipeline register. It performs loads and stores of 1, 2 or 4 bytes over a byte-wide memory-controller port, one byte per handshake. It holds the pipeline with `stall_req` until the access completes, then hands `rd_data_o`, `rd_addr_o` and `rd_enable_o` to the MEM/WB register. Non-memory instructions pass through combinationally with zero stall.

## Interface
- `AddrLen`, 32, address width.
- `RegLen`, 32, data width.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; asynchronous and active-low.
- `rd_data_i`  in  32  ALU result from EX; this is the load address for loads and the store data for stores.
- `rd_addr_i`  in  5  destination register.
- `rd_enable_i`  in  1  register write enable; 0 together with a nonzero width means store.
- `mem_addr_i`  in  32  store address; ignored for loads.
- `width_i`  in  4  `[2:0]` is the byte count (0 = no access, 1, 2, 4); `[3]` = zero-extend (LBU/LHU).
- `mem_req`  out  1  byte request valid.
- `mem_we`  out  1  1 = write.
- `mem_a`  out  32  byte address.
- `mem_dout`  out  8  write byte.
- `mem_gnt`  in  1  controller accepts the request this cycle.
- `mem_din`  in  8  read byte; valid the cycle after a read is accepted.
- `rd_data_o`  out  32  result to MEM/WB.
- `rd_addr_o`  out  5  destination register to MEM/WB.
- `rd_enable_o`  out  1  write enable to MEM/WB.
- `stall_req`  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- `misalign_o`  out  1  misaligned-access flag (see Configuration).

## Operation
- FSM states: `IDLE`, `ACCESS`, `WAIT_LAST`, `DONE`.
- IDLE, width[2:0]=0: outputs equal the inputs, `stall_req`=0.
- IDLE, width≠0: `stall_req`=1 (combinational). Latch base address, store data, byte count and sign mode. Clear byte index k. Go to ACCESS.
- Base address: `rd_data_i` for loads, `mem_addr_i` for stores.
- ACCESS: drive `mem_req`=1, `mem_a`=base+k (32-bit wrap-around), `mem_we`, and `mem_dout`=store_data[8k+7:8k].
- An accepted byte is one with `mem_req`&`mem_gnt` at the edge; k then increments. With `mem_gnt`=0, all request outputs hold steady.
- Read bytes are captured into buffer[8(k-1)+7 : 8(k-1)] the cycle after acceptance. This capture overlaps the next request.
- After the last byte is accepted: a load goes to WAIT_LAST, a store goes to DONE.
- WAIT_LAST: capture the final byte, then go to DONE.
- DONE: `stall_req`=0. `rd_data_o` = extended buffer for loads, or `rd_data_i` for stores. Return to IDLE on the next edge; EX/MEM advances on that same edge.
- Extension: 1 byte gives sign- or zero-extension of bit 7; 2 bytes use bit 15; 4 bytes pass through unchanged.
- Stores drive `rd_enable_o`=0 in every state. Loads drive `rd_enable_o`=`rd_enable_i` only in DONE and 0 while stalled.
- Reset value of all outputs is 0, and the state is IDLE. Reset asserted mid-access aborts immediately: `mem_req` drops and partially written bytes remain in memory.

## Timing
- Non-memory instruction: 0 extra cycles.
- Load of N bytes with `mem_gnt` held high: `stall_req` is high for N+2 cycles and the result is valid in cycle N+2 after entry. Word load: 7 cycles in the stage.
- Store of N bytes: `stall_req` is high for N+1 cycles.
- Each cycle of `mem_gnt` low adds one cycle.
- `mem_req` never asserts in IDLE or DONE.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - A halfword with addr[0]=1 or a word with addr[1:0]≠0 produces no memory request and no stall.
  - The stage drives `rd_enable_o`=0 and `misalign_o`=1 combinationally for the instruction's single cycle.
- `MEM_ALIGN_CHECK_EN` undefined:
  - Unaligned accesses proceed byte-wise.
  - `misalign_o` is tied to 0.

## Structure
- Shared package holds the width encodings (`WIDTH_NONE/B/H/W`, `WIDTH_UNSIGNED_BIT`) and the FSM state encoding, so ID and EX reuse them.
- Sub-module `load_extend`: combinational buffer + byte count + unsigned flag → 32-bit result. It is reused by a later data cache.

## Test plan
- ADD result 0x1234, rd=5, width=0 → same-cycle `rd_data_o`=0x1234, `rd_enable_o`=1, `stall_req`=0.
- LW at 0x100, memory 0x78,0x56,0x34,0x12, `mem_gnt`=1 → requests at 0x100..0x103, then `rd_data_o`=0x12345678 in cycle 6; `stall_req` high for 6 cycles.
- LB at 0x200 containing 0x80 → 0xFFFFFF80. LBU at the same address → 0x00000080. LH of 0xFF7F → 0xFFFFFF7F.
- SW 0xDEADBEEF to 0x300, `mem_gnt` low on the 2nd request for 3 cycles → writes EF, BE, AD, DE at 0x300..0x303; `mem_a` stable while stalled; `rd_enable_o`=0 throughout.
- Reset asserted during byte 2 of a word store → `mem_req`=0 at once, state IDLE, all outputs 0.
- LW at 0x102: with `MEM_ALIGN_CHECK_EN`, `misalign_o`=1 and no `mem_req`. Without it, bytes are read from 0x102..0x105.
